// File: rtl/conv_pkg.sv
// Shared constants, state encoding and result-address type for the first-stage
// convolution window scheduler.
package conv_pkg;

  localparam int IMG_DIM = 8;
  localparam int K_DIM   = 3;
  localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
  localparam int N_FILT  = 4;
  localparam int POS_W   = 6;
  localparam int FILT_W  = 2;
  localparam int COORD_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

  typedef logic [FILT_W+POS_W-1:0] res_addr_t;

  // Linear output position inside one filter plane; max 35 fits POS_W bits.
  function automatic logic [POS_W-1:0] pos_of(input logic [COORD_W-1:0] row,
                                              input logic [COORD_W-1:0] col);
    return POS_W'(row) * POS_W'(OUT_DIM) + POS_W'(col);
  endfunction

endpackage

// File: rtl/sched_delay_line.sv
// MAC-latency matching shift register: valid bit plus payload, all stages share
// one enable so a stall freezes the whole line.
module sched_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o,
  output logic         pend_o
);

  // Stage DEPTH-1 is the entry, stage 0 drives the outputs.
  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else if (en_i) begin
      vld_q[DEPTH-1] <= vld_i;
      dat_q[DEPTH-1] <= dat_i;
      for (int i = 0; i < DEPTH - 1; i++) begin
        vld_q[i] <= vld_q[i+1];
        dat_q[i] <= dat_q[i+1];
      end
    end
  end

  assign vld_o  = vld_q[0];
  assign dat_o  = dat_q[0];
  // Something still in flight behind the output stage.
  assign pend_o = |(vld_q >> 1);

endmodule

// File: rtl/conv_window_scheduler.sv
// Walks the 3x3 window over all output positions per filter and emits delayed
// result-BRAM writes; CONV_SCHED_PERF_EN adds stall/pass cycle counters.
module conv_window_scheduler
  import conv_pkg::*;
#(
  parameter int MAC_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    data_rdy,
  input  logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic [COORD_W-1:0]      win_row,
  output logic [COORD_W-1:0]      win_col,
  output logic [FILT_W-1:0]       filt_sel,
  output logic                    win_valid,
  output logic                    wr_en,
  output logic [FILT_W+POS_W-1:0] wr_addr
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [15:0]             stall_cycles,
  output logic [15:0]             pass_cycles
`endif
);

  sched_state_t        state_q, state_d;
  logic [COORD_W-1:0]  row_q, row_d;
  logic [COORD_W-1:0]  col_q, col_d;
  logic [FILT_W-1:0]   filt_q, filt_d;
  logic                issue;
  logic                start_acc;
  logic                dl_vld;
  logic                dl_pend;
  res_addr_t           dl_dat;
  res_addr_t           issue_addr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      filt_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      filt_q  <= filt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    filt_d    = filt_q;
    issue     = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WAIT_DATA;
          start_acc = 1'b1;
          row_d     = '0;
          col_d     = '0;
          filt_d    = '0;
        end
      end
      WAIT_DATA: begin
        if (data_rdy) state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          issue = 1'b1;
          // Column fastest, then row, then filter; the final window ends the walk.
          if (col_q == COORD_W'(OUT_DIM - 1)) begin
            col_d = '0;
            if (row_q == COORD_W'(OUT_DIM - 1)) begin
              row_d = '0;
              if (filt_q == FILT_W'(N_FILT - 1)) begin
                filt_d  = '0;
                state_d = DRAIN;
              end else begin
                filt_d = filt_q + 1'b1;
              end
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Leave once the output stage holds the last write and nothing is behind it.
        if (!stall && !dl_pend) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign issue_addr = {filt_q, pos_of(row_q, col_q)};

  sched_delay_line #(
    .DEPTH (MAC_LAT),
    .W     (FILT_W + POS_W)
  ) u_delay (
    .clk_i   (clk),
    .rst_n_i (reset),
    .en_i    (!stall),
    .vld_i   (issue),
    .dat_i   (issue_addr),
    .vld_o   (dl_vld),
    .dat_o   (dl_dat),
    .pend_o  (dl_pend)
  );

  assign busy      = (state_q == WAIT_DATA) || (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign win_row   = row_q;
  assign win_col   = col_q;
  assign filt_sel  = filt_q;
  assign win_valid = issue;
  assign wr_en     = dl_vld && !stall;
  assign wr_addr   = dl_dat;

`ifdef CONV_SCHED_PERF_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] pass_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      pass_cnt_q  <= '0;
    end else if (start_acc) begin
      stall_cnt_q <= '0;
      pass_cnt_q  <= '0;
    end else begin
      if ((state_q == RUN || state_q == DRAIN) && stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      // Every non-idle cycle up to and including the done pulse.
      if (state_q != IDLE && pass_cnt_q != 16'hFFFF)
        pass_cnt_q <= pass_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign pass_cycles  = pass_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Drives two schedulers (MAC_LAT 1 and 3) with shared stimulus and checks both
// against an issue/write-order model derived from plain index arithmetic.
module tb_conv_window_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       data_rdy = 1'b0;
  logic       stall = 1'b0;

  logic       busy1, done1, wv1, we1;
  logic [2:0] row1, col1;
  logic [1:0] f1;
  logic [7:0] a1;
  logic       busy3, done3, wv3, we3;
  logic [2:0] row3, col3;
  logic [1:0] f3;
  logic [7:0] a3;
`ifdef CONV_SCHED_PERF_EN
  logic [15:0] sc1, pc1, sc3, pc3;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int u = 0;

  int n_iss[2], n_wr[2], n_done[2];
  int st_cyc[2], rdy_cyc[2], done_cyc[2], last_wr_cyc[2];
  bit rdy_seen[2], active[2];
  int iss_u[2][144];

  always #5 clk = ~clk;

  conv_window_scheduler #(.MAC_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .data_rdy(data_rdy), .stall(stall),
    .busy(busy1), .done(done1), .win_row(row1), .win_col(col1), .filt_sel(f1),
    .win_valid(wv1), .wr_en(we1), .wr_addr(a1)
`ifdef CONV_SCHED_PERF_EN
    , .stall_cycles(sc1), .pass_cycles(pc1)
`endif
  );

  conv_window_scheduler #(.MAC_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .data_rdy(data_rdy), .stall(stall),
    .busy(busy3), .done(done3), .win_row(row3), .win_col(col3), .filt_sel(f3),
    .win_valid(wv3), .wr_en(we3), .wr_addr(a3)
`ifdef CONV_SCHED_PERF_EN
    , .stall_cycles(sc3), .pass_cycles(pc3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model: the k-th issue is window (k/36, (k%36)/6, k%6); the k-th
  // write carries f*64+pos and lands MAC_LAT unstalled cycles after its issue.
  task automatic mon(input int d, input int lat, input logic bz, input logic dn,
                     input logic wv, input logic [2:0] r, input logic [2:0] c,
                     input logic [1:0] f, input logic we, input logic [7:0] a);
    int k;
    if (!reset) begin
      active[d] = 1'b0;
    end else begin
      if (start && !bz && !dn) begin
        active[d] = 1'b1; n_iss[d] = 0; n_wr[d] = 0; n_done[d] = 0;
        rdy_seen[d] = 1'b0; st_cyc[d] = cyc;
      end
      if (bz && data_rdy && !rdy_seen[d]) begin
        rdy_seen[d] = 1'b1; rdy_cyc[d] = cyc;
      end
      if (stall) chk("stall_quiet", 32'({wv, we}), 0);
      if (active[d] && rdy_seen[d] && cyc > rdy_cyc[d] && !stall && n_iss[d] < 144)
        chk("issue_gap", 32'(wv), 1);
      if (wv) begin
        k = n_iss[d];
        chk("issue_after_rdy", 32'(rdy_seen[d] && cyc > rdy_cyc[d]), 1);
        if (k < 144) begin
          chk("win_filt", 32'(f), k / 36);
          chk("win_row", 32'(r), (k % 36) / 6);
          chk("win_col", 32'(c), k % 6);
          iss_u[d][k] = u;
        end else begin
          chk("issue_extra", k, 143);
        end
        n_iss[d]++;
      end
      if (we) begin
        k = n_wr[d];
        if (k < n_iss[d] && k < 144) begin
          chk("wr_addr", 32'(a), (k / 36) * 64 + k % 36);
          chk("wr_lat", u - iss_u[d][k], lat);
        end else begin
          chk("wr_count", k + 1, (n_iss[d] < 144) ? n_iss[d] : 144);
        end
        n_wr[d]++;
        last_wr_cyc[d] = cyc;
      end
      if (dn) begin
        n_done[d]++;
        done_cyc[d] = cyc;
        chk("done_after_wr", cyc - last_wr_cyc[d], 1);
        chk("done_writes", n_wr[d], 144);
        active[d] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, 1, busy1, done1, wv1, row1, col1, f1, we1, a1);
    mon(1, 3, busy3, done3, wv3, row3, col3, f3, we3, a3);
    if (!stall) u++;
    cyc++;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int stall_at, input int mid_at);
    int  stall_rem = 0;
    bit  stall_fired = 1'b0;
    bit  mid_fired = 1'b0;
    bit  ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (n_done[0] > 0 && n_done[1] > 0) begin
        ok = 1'b1;
        break;
      end
      start = 1'b0;
      if (stall_at >= 0 && !stall_fired && n_iss[0] >= stall_at) begin
        stall_rem = 5; stall_fired = 1'b1;
      end
      if (stall_rem > 0) begin
        stall = 1'b1; stall_rem--;
      end else begin
        stall = rnd && ($urandom_range(3) == 0);
      end
      if (mid_at >= 0 && !mid_fired && n_iss[0] >= mid_at) begin
        start = 1'b1; mid_fired = 1'b1;
      end
      if (rnd) begin
        if ($urandom_range(19) == 0) start = 1'b1;
        if (n_iss[0] > 0) data_rdy = 1'($urandom_range(1));
      end
    end
    start = 1'b0;
    stall = 1'b0;
    chk("done_seen", 32'(ok), 1);
    repeat (4) @(posedge clk);
    #1;
    chk("single_done", n_done[0] + n_done[1], 2);
    chk("idle_after", 32'({busy1, busy3}), 0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_win_valid", 32'(wv1), 0);
    chk("rst_wr_en", 32'({we1, we3}), 0);
    chk("rst_wr_addr", 32'(a1), 0);
    chk("rst_coords", 32'({f1, row1, col1}), 0);
`ifdef CONV_SCHED_PERF_EN
    chk("rst_perf", 32'({sc1, pc1}), 0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // Plain pass, data already loaded.
    data_rdy = 1'b1;
    pulse_start();
    wait_done(1'b0, -1, -1);
    chk("lat_plain_l1", done_cyc[0] - st_cyc[0], 147);
    chk("lat_plain_l3", done_cyc[1] - st_cyc[1], 149);

    // Five-cycle stall after 40 issues.
    pulse_start();
    wait_done(1'b0, 40, -1);
    chk("lat_stall_l1", done_cyc[0] - st_cyc[0], 152);
    chk("lat_stall_l3", done_cyc[1] - st_cyc[1], 154);
`ifdef CONV_SCHED_PERF_EN
    chk("perf_stall_l1", 32'(sc1), 5);
    chk("perf_stall_l3", 32'(sc3), 5);
    chk("perf_pass_l1", 32'(pc1), 152);
    chk("perf_pass_l3", 32'(pc3), 154);
`endif

    // Data arrives late; a second start mid-run must be ignored.
    data_rdy = 1'b0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      chk("wait_busy", 32'({busy1, busy3}), 3);
      chk("wait_no_issue", 32'({wv1, wv3}), 0);
      @(posedge clk); #1;
    end
    data_rdy = 1'b1;
    wait_done(1'b0, -1, 60);
    chk("rdy_wait_len", rdy_cyc[0] - st_cyc[0], 11);
    chk("lat_rdy_l1", done_cyc[0] - rdy_cyc[0], 146);
    chk("lat_rdy_l3", done_cyc[1] - rdy_cyc[1], 148);

    // Reset in the middle of a pass, then a clean pass.
    pulse_start();
    for (int i = 0; i < 300; i++) begin
      if (n_iss[0] >= 70) break;
      @(posedge clk); #1;
    end
    chk("reach_issue_70", n_iss[0], 70);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'({busy1, busy3}), 0);
    chk("abort_wr_en", 32'({we1, we3}), 0);
    chk("abort_win_valid", 32'({wv1, wv3}), 0);
    chk("abort_wr_addr", 32'(a1), 0);
    reset = 1'b1;
    pulse_start();
    wait_done(1'b0, -1, -1);
    chk("lat_after_abort_l1", done_cyc[0] - st_cyc[0], 147);
    chk("lat_after_abort_l3", done_cyc[1] - st_cyc[1], 149);

    // Randomised stalls, load delay, stray starts and data_rdy wiggle.
    for (int p = 0; p < 4; p++) begin
      data_rdy = 1'b0;
      pulse_start();
      repeat ($urandom_range(5)) begin
        @(posedge clk); #1;
      end
      data_rdy = 1'b1;
      wait_done(1'b1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
